tick_rate_sel: RTL and testbench
================================

Name: tick_rate_sel

Overview:
Parametrised successor to the two-rate adjust/normal clock selector. Generates one-cycle tick enables at NUM_RATES binary-related rates, all derived from the single system clock. Selects the active rate through a multi-bit mode input. Rate changes take effect only on period boundaries, so no runt or stretched periods. Adds pause and restart. Sits between the board clock and the stopwatch/clock counters; downstream logic runs on clk gated by tick, never on derived clocks.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz
BASE_HZ, 1, slowest tick rate (rate index 0) in Hz
NUM_RATES, 4, number of selectable rates; rate k = BASE_HZ << k
SEL_W, $clog2(NUM_RATES) (min 1), width of the rate select

Ports:
clk  in  1  system clock; all logic on its rising edge
rst_n  in  1  synchronous active-low reset
rate_sel  in  SEL_W  requested rate index; values >= NUM_RATES are treated as NUM_RATES-1
pause  in  1  level; holds the counter, no ticks while high
restart  in  1  one-cycle pulse; restarts the current period from zero
tick  out  1  one-cycle pulse at the end of each period of the active rate
blink  out  1  level; toggles on every tick (50% square at half the tick rate)
rate_cur  out  SEL_W  rate index currently in effect

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Ports are clk and rst_n.
- PERIOD(k) = CLK_HZ / (BASE_HZ << k), integer division. Elaboration error if PERIOD(NUM_RATES-1) < 2.
- Counter width: $clog2(PERIOD(0)).
- Reset (rst_n = 0 at a clk edge): cnt = 0, tick = 0, blink = 0, rate_cur = clamp(rate_sel), pending cleared.
- Reset mid-period discards all progress.
- Count: when not paused, cnt increments each cycle.
  - When cnt == PERIOD(rate_cur) - 1: cnt goes to 0 and tick = 1 in the following cycle (tick is registered; latency 1 from the terminal count).
  - The first tick after reset is asserted exactly PERIOD(rate_cur) cycles after the cycle in which rst_n deasserts.
- blink toggles in the same cycle that tick is high.
- Rate change: the request is captured when clamp(rate_sel) != rate_cur.
  - rate_cur is updated at the terminal-count cycle, so the next period uses the new length.
  - The current period always completes at the old length.
  - If rate_sel changes again before the boundary, the latest value wins.
  - If rate_sel returns to rate_cur before the boundary, the pending change is cancelled.
- Priority each cycle: rst_n low > restart > pause > count.
- restart:
  - cnt = 0, no tick that cycle, any pending rate applied immediately.
  - blink is unchanged.
  - restart while paused restarts the period; the hold continues.
- pause:
  - cnt frozen, tick forced 0, rate change remains pending.
  - Deasserting pause resumes from the frozen cnt.
  - If pause rises in the cycle a tick is due, the tick is suppressed until resume.
- Single-cycle period edge cases: none (PERIOD >= 2 enforced).
- Back-to-back ticks are never emitted.

Decomposition:
- Package clk_rate_pkg holds:
  - function period_of(k, CLK_HZ, BASE_HZ)
  - function clamp_sel
  - localparam CNT_W derivation helper
- One sub-module, tick_counter: a loadable up-counter with terminal-count input, hold, clear and registered tick output.
- tick_rate_sel owns select clamping, the pending-rate register, priority logic and blink.

Test Plan:
Bench uses CLK_HZ=16, BASE_HZ=1, NUM_RATES=3 (periods 16/8/4).
1. Reset release with rate_sel=0 -> first tick 16 cycles after release, then every 16 cycles; blink toggles with each tick; rate_cur=0.
2. rate_sel 0->2 at cnt=5 -> tick at cnt=15 boundary as normal, then ticks every 4 cycles; rate_cur=2 from that boundary onward.
3. rate_sel 2->0->2 within one period -> no change; period stays 4; rate_sel=3 -> clamped, rate_cur=2.
4. pause high for 10 cycles at cnt=6 of an 8-cycle period -> no tick; tick arrives 2 cycles after pause falls; pause over a due tick suppresses it.
5. restart at cnt=12 (rate 0) with pending rate 1 -> next tick 8 cycles later; blink unchanged at restart; restart+pause together -> cnt=0 and held.
6. rst_n low at cnt=10 with blink=1 -> next cycle: tick=0, blink=0, cnt=0; first tick a full period after release.

Source files
------------

// File: rtl/clk_rate_pkg.sv
// Shared constants and helpers for the tick rate selector: period math,
// select clamping and counter width derivation.
package clk_rate_pkg;

  // Clock cycles per period of rate k (rate k runs at base_hz << k).
  function automatic int period_of(input int k, input int clk_hz, input int base_hz);
    return clk_hz / (base_hz << k);
  endfunction

  // Out-of-range select values map onto the fastest rate.
  function automatic int clamp_sel(input int sel, input int num_rates);
    return (sel >= num_rates) ? (num_rates - 1) : sel;
  endfunction

  function automatic int cnt_width(input int period);
    return (period < 2) ? 1 : $clog2(period);
  endfunction

endpackage

// File: rtl/tick_rate_sel_if.sv
// Control/status bundle between the board-level controls and the tick rate selector.
interface tick_rate_sel_if #(
  parameter int SEL_W = 2
) ();
  // No valid/ready handshake: rate_sel and pause are levels sampled every
  // clock, restart is a one-cycle pulse, tick is a one-cycle pulse.
  logic [SEL_W-1:0] rate_sel;
  logic             pause;
  logic             restart;
  logic             tick;
  logic             blink;
  logic [SEL_W-1:0] rate_cur;

  modport master (
    output rate_sel, pause, restart,
    input  tick, blink, rate_cur
  );

  modport slave (
    input  rate_sel, pause, restart,
    output tick, blink, rate_cur
  );
endinterface

// File: rtl/tick_counter.sv
// Up-counter that wraps at a supplied terminal value and emits a registered
// one-cycle tick on the cycle after the wrap. Clear beats hold.
module tick_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             hold,
  input  logic [CNT_W-1:0] term,
  output logic             tc,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  assign tc   = (cnt_q == term);
  assign tick = tick_q;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (hold) begin
      cnt_d = cnt_q;
    end else if (tc) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/tick_rate_sel.sv
// Multi-rate tick generator: one-cycle tick enables at BASE_HZ << k, with
// rate changes deferred to period boundaries, plus pause, restart and blink.
import clk_rate_pkg::*;

module tick_rate_sel #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BASE_HZ   = 1,
  parameter int NUM_RATES = 4,
  parameter int SEL_W     = (NUM_RATES > 1) ? $clog2(NUM_RATES) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  tick_rate_sel_if.slave bus
);

  localparam int CNT_W = cnt_width(period_of(0, CLK_HZ, BASE_HZ));

  if (period_of(NUM_RATES - 1, CLK_HZ, BASE_HZ) < 2) begin : g_bad_period
    $error("tick_rate_sel: fastest rate period must be at least 2 clocks");
  end

  logic [SEL_W-1:0] sel_c;
  logic [SEL_W-1:0] rate_cur_q, rate_cur_d;
  logic [SEL_W-1:0] pend_rate_q, pend_rate_d;
  logic             pend_valid_q, pend_valid_d;
  logic             blink_q, blink_d;
  logic [CNT_W-1:0] term;
  logic             tc;
  logic             tick;

  assign sel_c = SEL_W'(clamp_sel(int'(bus.rate_sel), NUM_RATES));

  // Terminal count for the rate in effect; each arm folds to a constant.
  always_comb begin
    term = '0;
    for (int i = 0; i < NUM_RATES; i++) begin
      if (int'(rate_cur_q) == i) begin
        term = CNT_W'(period_of(i, CLK_HZ, BASE_HZ) - 1);
      end
    end
  end

  tick_counter #(
    .CNT_W (CNT_W)
  ) u_tick_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (bus.restart),
    .hold  (bus.pause),
    .term  (term),
    .tc    (tc),
    .tick  (tick)
  );

  // A pending rate is applied on restart or at a non-paused wrap, so the
  // period in flight always finishes at its original length.
  always_comb begin
    rate_cur_d = rate_cur_q;
    blink_d    = blink_q;
    if (bus.restart) begin
      if (pend_valid_q) rate_cur_d = pend_rate_q;
    end else if (!bus.pause && tc) begin
      if (pend_valid_q) rate_cur_d = pend_rate_q;
      blink_d = ~blink_q;
    end
    pend_rate_d  = sel_c;
    pend_valid_d = (sel_c != rate_cur_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rate_cur_q   <= sel_c;
      pend_rate_q  <= '0;
      pend_valid_q <= 1'b0;
      blink_q      <= 1'b0;
    end else begin
      rate_cur_q   <= rate_cur_d;
      pend_rate_q  <= pend_rate_d;
      pend_valid_q <= pend_valid_d;
      blink_q      <= blink_d;
    end
  end

  assign bus.tick     = tick;
  assign bus.blink    = blink_q;
  assign bus.rate_cur = rate_cur_q;

endmodule

// File: tb/tb_tick_rate_sel.sv
// Directed bench for tick_rate_sel with periods 16/8/4: expected tick gaps and
// rates are queued as stimulus is applied and popped as ticks appear.
module tb_tick_rate_sel;

  localparam int CLK_HZ    = 16;
  localparam int BASE_HZ   = 1;
  localparam int NUM_RATES = 3;
  localparam int SEL_W     = 2;
  localparam int W         = 16;
  localparam int MAX_WAIT  = 40;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  tick_rate_sel_if #(.SEL_W(SEL_W)) bus ();

  tick_rate_sel #(
    .CLK_HZ    (CLK_HZ),
    .BASE_HZ   (BASE_HZ),
    .NUM_RATES (NUM_RATES),
    .SEL_W     (SEL_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int          n_checks  = 0;
  int          n_fail    = 0;
  logic        exp_blink = 1'b0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Gap is counted in cycles from the current sampling point to the tick.
  task automatic push_tick(input int gap, input int rate);
    exp_q.push_back({4'(rate), 12'(gap)});
  endtask

  task automatic drain(input string tag);
    logic [W-1:0] e;
    int           k;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!bus.tick && k <= MAX_WAIT);
      check({tag, " tick gap"}, 32'(k), 32'(e[11:0]));
      check({tag, " rate_cur"}, 32'(bus.rate_cur), 32'(e[15:12]));
      exp_blink = ~exp_blink;
      check({tag, " blink"}, 32'(bus.blink), 32'(exp_blink));
    end
  endtask

  task automatic hold_no_tick(input string tag, input int n);
    repeat (n) begin
      @(negedge clk);
      check({tag, " no tick"}, 32'(bus.tick), 32'd0);
    end
  endtask

  initial begin
    bus.rate_sel = 2'd3;
    bus.pause    = 1'b0;
    bus.restart  = 1'b0;

    // Reset with an out-of-range select, then with rate 0.
    step(2);
    check("reset clamp rate_cur", 32'(bus.rate_cur), 32'd2);
    check("reset tick", 32'(bus.tick), 32'd0);
    check("reset blink", 32'(bus.blink), 32'd0);
    bus.rate_sel = 2'd0;
    step(1);
    check("reset rate_cur", 32'(bus.rate_cur), 32'd0);
    rst_n = 1'b1;

    // 1: period 16 from release.
    push_tick(16, 0);
    push_tick(16, 0);
    push_tick(16, 0);
    drain("t1");

    // 2: request rate 2 at cnt=5; current period finishes at 16.
    step(5);
    bus.rate_sel = 2'd2;
    step(1);
    check("t2 rate_cur before boundary", 32'(bus.rate_cur), 32'd0);
    push_tick(10, 2);
    push_tick(4, 2);
    push_tick(4, 2);
    drain("t2");

    // 3: 2->0->2 inside one period is a no-op; select 3 clamps to 2.
    step(1);
    bus.rate_sel = 2'd0;
    step(1);
    bus.rate_sel = 2'd2;
    push_tick(2, 2);
    push_tick(4, 2);
    drain("t3 cancel");
    bus.rate_sel = 2'd3;
    push_tick(4, 2);
    push_tick(4, 2);
    drain("t3 clamp");

    // 4: move to rate 1, then pause 10 cycles at cnt=6.
    bus.rate_sel = 2'd1;
    push_tick(4, 1);
    push_tick(8, 1);
    drain("t4 to rate1");
    step(6);
    bus.pause = 1'b1;
    hold_no_tick("t4 pause", 10);
    bus.pause = 1'b0;
    push_tick(2, 1);
    drain("t4 resume");
    // Pause raised while the terminal count is pending.
    step(7);
    bus.pause = 1'b1;
    hold_no_tick("t4 due pause", 3);
    bus.pause = 1'b0;
    push_tick(1, 1);
    push_tick(8, 1);
    drain("t4 due resume");

    // 5: restart at cnt=12 of rate 0 with rate 1 pending.
    bus.rate_sel = 2'd0;
    push_tick(8, 0);
    drain("t5 to rate0");
    step(3);
    bus.rate_sel = 2'd1;
    step(9);
    check("t5 rate_cur pending", 32'(bus.rate_cur), 32'd0);
    bus.restart = 1'b1;
    step(1);
    bus.restart = 1'b0;
    check("t5 restart rate_cur", 32'(bus.rate_cur), 32'd1);
    check("t5 restart blink", 32'(bus.blink), 32'(exp_blink));
    check("t5 restart tick", 32'(bus.tick), 32'd0);
    push_tick(8, 1);
    drain("t5 after restart");
    // Restart together with pause clears and keeps holding.
    step(3);
    bus.pause   = 1'b1;
    bus.restart = 1'b1;
    step(1);
    bus.restart = 1'b0;
    hold_no_tick("t5 restart+pause", 4);
    bus.pause = 1'b0;
    push_tick(8, 1);
    drain("t5 release");

    // 6: reset at cnt=10 of rate 0 with blink high.
    bus.rate_sel = 2'd0;
    push_tick(8, 0);
    drain("t6 to rate0");
    step(10);
    check("t6 blink before reset", 32'(bus.blink), 32'(exp_blink));
    rst_n = 1'b0;
    step(1);
    check("t6 reset tick", 32'(bus.tick), 32'd0);
    check("t6 reset blink", 32'(bus.blink), 32'd0);
    check("t6 reset rate_cur", 32'(bus.rate_cur), 32'd0);
    rst_n     = 1'b1;
    exp_blink = 1'b0;
    push_tick(16, 0);
    drain("t6 after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
